// File: rtl/conv_relu_maxpool_stream.sv
// Streaming ReLU + 2x2/stride-2 max-pool over raster-ordered float16 conv maps.
// Define CONV_POOL_RELU_EN to clamp negatives to zero before pooling; otherwise signed float16 ordering is used.
module conv_relu_maxpool_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int H          = 160,
  parameter int W          = 160,
  parameter int K          = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  frame_done
);

  localparam int CW    = (W > 1) ? $clog2(W) : 1;
  localparam int RW    = (H > 1) ? $clog2(H) : 1;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;
  localparam int LD    = (W / 2 > 0) ? W / 2 : 1;
  localparam int LW    = (LD > 1) ? $clog2(LD) : 1;
  localparam bit W_ODD = (W % 2) == 1;
  localparam bit H_ODD = (H % 2) == 1;

  localparam logic [DATA_WIDTH-1:0] SIGN_BIT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // The MSB is the float16 sign bit; exponent and mantissa follow towards the LSB.
  function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] x);
`ifdef CONV_POOL_RELU_EN
    return x[DATA_WIDTH-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  // Ordering key: unsigned compare of keys matches float ordering (NaN excepted).
  function automatic logic [DATA_WIDTH-1:0] cmp_key(input logic [DATA_WIDTH-1:0] x);
`ifdef CONV_POOL_RELU_EN
    return x;
`else
    if (x == SIGN_BIT)           return SIGN_BIT;
    else if (x[DATA_WIDTH-1])    return ~x;
    else                         return x | SIGN_BIT;
`endif
  endfunction

  // Ties keep the earlier operand.
  function automatic logic [DATA_WIDTH-1:0] pick_max(input logic [DATA_WIDTH-1:0] earlier,
                                                    input logic [DATA_WIDTH-1:0] later);
    return (cmp_key(later) > cmp_key(earlier)) ? later : earlier;
  endfunction

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [KW-1:0]         ch_q, ch_d;
  logic [DATA_WIDTH-1:0] pair_q, pair_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  frame_done_q, frame_done_d;

  logic [DATA_WIDTH-1:0] lbuf_q [LD];
  logic                  lbuf_we;
  logic [LW-1:0]         lbuf_idx;
  logic [DATA_WIDTH-1:0] lbuf_wdata;

  logic                  accept;
  logic                  col_last, row_last, ch_last;
  logic                  in_window;
  logic [DATA_WIDTH-1:0] x;

  assign in_ready  = reset & (~out_valid_q | out_ready);
  assign accept    = in_valid & in_ready;
  assign x         = relu(in_data);

  assign col_last  = (col_q == CW'(W - 1));
  assign row_last  = (row_q == RW'(H - 1));
  assign ch_last   = (ch_q  == KW'(K - 1));
  assign in_window = !(W_ODD && col_last) && !(H_ODD && row_last);
  assign lbuf_idx  = LW'(col_q >> 1);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    col_d        = col_q;
    row_d        = row_q;
    ch_d         = ch_q;
    pair_d       = pair_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q & ~out_ready;
    frame_done_d = 1'b0;
    lbuf_we      = 1'b0;
    lbuf_wdata   = pick_max(pair_q, x);

    if (accept) begin
      col_d        = col_last ? '0 : col_q + CW'(1);
      frame_done_d = col_last & row_last & ch_last;
      if (col_last) begin
        row_d = row_last ? '0 : row_q + RW'(1);
        if (row_last) ch_d = ch_last ? '0 : ch_q + KW'(1);
      end

      // Even column parks the left half of a window; odd column closes it.
      if (in_window) begin
        if (!col_q[0]) begin
          pair_d = x;
        end else if (!row_q[0]) begin
          lbuf_we = 1'b1;
        end else begin
          out_data_d  = pick_max(pick_max(lbuf_q[lbuf_idx], pair_q), x);
          out_valid_d = 1'b1;
        end
      end
    end
  end

  // NOTE: state flops use non-blocking assignments only; all next-state logic lives in always_comb.
  always_ff @(posedge clk) begin
    if (!reset) begin
      col_q        <= '0;
      row_q        <= '0;
      ch_q         <= '0;
      pair_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      ch_q         <= ch_d;
      pair_q       <= pair_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // NOTE: the line buffer has no reset; an even row rewrites every entry before an odd row reads it.
  always_ff @(posedge clk) begin
    if (lbuf_we) lbuf_q[lbuf_idx] <= lbuf_wdata;
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_relu_maxpool_stream.sv
// Scoreboard bench for conv_relu_maxpool_stream: three instances (4x4x1, 5x5x2, 2x2x3),
// one active at a time; expected pooled values are queued as stimulus is driven.
module tb_conv_relu_maxpool_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid   [3];
  logic [15:0] in_data    [3];
  logic        out_ready  [3];
  logic        in_ready   [3];
  logic        out_valid  [3];
  logic [15:0] out_data   [3];
  logic        frame_done [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int GS = (g == 0) ? 4 : (g == 1) ? 5 : 2;
    localparam int GK = (g == 0) ? 1 : (g == 1) ? 2 : 3;
    conv_relu_maxpool_stream #(
      .DATA_WIDTH(16), .H(GS), .W(GS), .K(GK)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .frame_done(frame_done[g])
    );
  end

  int          n_cmp = 0;
  int          n_fail = 0;
  int          sel = 0;
  int          n_out = 0;
  int          acc_cnt = 0;
  int          fd_cnt = 0;
  int          fd_at_acc = -1;
  bit          drive_done;
  logic [15:0] sb_exp;
  logic [15:0] exp_q   [$];
  logic [15:0] stage_q [$];
  logic [15:0] map_q   [$];

  // Scoreboard monitor on the active instance; samples on the falling edge.
  always @(negedge clk) begin
    if (frame_done[sel]) begin
      fd_cnt++;
      fd_at_acc = acc_cnt;
    end
    if (in_valid[sel] && in_ready[sel]) acc_cnt++;
    if (out_valid[sel] && out_ready[sel]) begin
      n_out++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra_output dut%0d: got %h, expected no output", sel, out_data[sel]);
      end else begin
        sb_exp = exp_q.pop_front();
        if (out_data[sel] !== sb_exp) begin
          n_fail++;
          $display("FAIL sb_out_data dut%0d: got %h, expected %h", sel, out_data[sel], sb_exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: exact float16 value scaled by 2^24 as a signed integer.
  function automatic longint fp_val(input logic [15:0] v);
    longint mag;
    int     e;
    e = int'(v[14:10]);
    if (e == 0) mag = longint'(v[9:0]);
    else        mag = longint'({1'b1, v[9:0]}) << (e - 1);
    return v[15] ? -mag : mag;
  endfunction

  function automatic logic [15:0] apply_relu(input logic [15:0] v);
`ifdef CONV_POOL_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [15:0] rand_fp();
    logic [15:0] v;
    v = 16'($urandom);
    if (v[14:10] == 5'h1f) v[14] = 1'b0;
    return v;
  endfunction

  task automatic model_pool(input int h, input int w, input int k);
    int          base;
    int          idx [4];
    logic [15:0] best, v;
    for (int ch = 0; ch < k; ch++)
      for (int r = 0; r + 1 < h; r += 2)
        for (int c = 0; c + 1 < w; c += 2) begin
          base   = ch * h * w + r * w + c;
          idx[0] = base; idx[1] = base + 1; idx[2] = base + w; idx[3] = base + w + 1;
          best   = apply_relu(map_q[idx[0]]);
          for (int j = 1; j < 4; j++) begin
            v = apply_relu(map_q[idx[j]]);
            if (fp_val(v) > fp_val(best)) best = v;
          end
          stage_q.push_back(best);
        end
  endtask

  task automatic send(input int g, input logic [15:0] d, output int waits);
    logic ok;
    waits       = 0;
    in_valid[g] = 1'b1;
    in_data[g]  = d;
    forever begin
      @(negedge clk);
      ok = in_ready[g];
      @(posedge clk);
      #1;
      if (ok) break;
      waits++;
      if (waits > 200) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout dut%0d: in_ready low for %0d cycles, expected accept", g, waits);
        break;
      end
    end
    in_valid[g] = 1'b0;
  endtask

  task automatic send_elem(input int g, input int i, input int h, input int w, output int waits);
    int p, r, c;
    p = i % (h * w);
    r = p / w;
    c = p % w;
    send(g, map_q[i], waits);
    if ((r % 2 == 1) && (c % 2 == 1) && (r < (h / 2) * 2) && (c < (w / 2) * 2))
      exp_q.push_back(stage_q.pop_front());
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic start_test(input int g);
    sel = g;
    map_q.delete();
    stage_q.delete();
    exp_q.delete();
    acc_cnt   = 0;
    fd_cnt    = 0;
    fd_at_acc = -1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int g = 0; g < 3; g++) begin
      in_valid[g]  = 1'b0;
      in_data[g]   = '0;
      out_ready[g] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      n_cmp++;
      if (out_valid[g] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid dut%0d: got %b, expected 0", g, out_valid[g]); end
      n_cmp++;
      if (out_data[g] !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data dut%0d: got %h, expected 0000", g, out_data[g]); end
      n_cmp++;
      if (frame_done[g] !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done dut%0d: got %b, expected 0", g, frame_done[g]); end
      n_cmp++;
      if (in_ready[g] !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready dut%0d: got %b, expected 0", g, in_ready[g]); end
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      n_cmp++;
      if (in_ready[g] !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready dut%0d: got %b, expected 1", g, in_ready[g]); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [15:0] vals [16];
    int          w0, out0;
    vals = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800,
             16'h4880, 16'h4900, 16'h4980, 16'h4A00, 16'h4A80, 16'h4B00, 16'h4B80, 16'h4C00};
    start_test(0);
    out0 = n_out;
    for (int i = 0; i < 16; i++) map_q.push_back(vals[i]);
    stage_q.push_back(16'h4600);
    stage_q.push_back(16'h4800);
    stage_q.push_back(16'h4B00);
    stage_q.push_back(16'h4C00);
    for (int i = 0; i < 16; i++) begin
      send_elem(0, i, 4, 4, w0);
      if (i == 4) begin
        n_cmp++;
        if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL basic_latency_early: out_valid %b, expected 0", out_valid[0]); end
      end
      if (i == 5) begin
        n_cmp++;
        if (out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL basic_latency_rise: out_valid %b, expected 1", out_valid[0]); end
      end
    end
    wait_drain();
    n_cmp++;
    if (n_out - out0 != 4) begin n_fail++; $display("FAIL basic_out_count: got %0d, expected 4", n_out - out0); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_missing: %0d outputs missing, expected 0", exp_q.size()); end
    n_cmp++;
    if (fd_cnt != 1) begin n_fail++; $display("FAIL basic_frame_done_count: got %0d, expected 1", fd_cnt); end
    n_cmp++;
    if (fd_at_acc != 16) begin n_fail++; $display("FAIL basic_frame_done_time: after %0d accepts, expected 16", fd_at_acc); end
  endtask

  task automatic test_sign();
    logic [15:0] top [8];
    int          w0, out0;
    top = '{16'hC000, 16'hBC00, 16'hC000, 16'hBC00, 16'hB800, 16'h8000, 16'hB800, 16'hC200};
    start_test(0);
    out0 = n_out;
    for (int i = 0; i < 8; i++)  map_q.push_back(top[i]);
    for (int i = 8; i < 16; i++) map_q.push_back(rand_fp());
    model_pool(4, 4, 1);
`ifdef CONV_POOL_RELU_EN
    stage_q[0] = 16'h0000;
    stage_q[1] = 16'h0000;
`else
    stage_q[0] = 16'h8000;
    stage_q[1] = 16'hB800;
`endif
    for (int i = 0; i < 16; i++) send_elem(0, i, 4, 4, w0);
    wait_drain();
    n_cmp++;
    if (n_out - out0 != 4) begin n_fail++; $display("FAIL sign_out_count: got %0d, expected 4", n_out - out0); end
    n_cmp++;
    if (fd_cnt != 1) begin n_fail++; $display("FAIL sign_frame_done_count: got %0d, expected 1", fd_cnt); end
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    int          w0, out0, out_before, acc_before;
    start_test(0);
    out0 = n_out;
    for (int i = 0; i < 16; i++) map_q.push_back(rand_fp());
    model_pool(4, 4, 1);
    out_ready[0] = 1'b0;
    for (int i = 0; i < 6; i++) send_elem(0, i, 4, 4, w0);
    held         = exp_q[0];
    acc_before   = acc_cnt;
    in_valid[0]  = 1'b1;
    in_data[0]   = map_q[6];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cycle %0d: got %b, expected 0", k, in_ready[0]); end
      n_cmp++;
      if (out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid cycle %0d: got %b, expected 1", k, out_valid[0]); end
      n_cmp++;
      if (out_data[0] !== held) begin n_fail++; $display("FAIL bp_out_data_held cycle %0d: got %h, expected %h", k, out_data[0], held); end
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (acc_cnt != acc_before) begin n_fail++; $display("FAIL bp_no_accept: %0d accepts during stall, expected 0", acc_cnt - acc_before); end
    out_before   = n_out;
    out_ready[0] = 1'b1;
    send_elem(0, 6, 4, 4, w0);
    n_cmp++;
    if (n_out - out_before != 1) begin n_fail++; $display("FAIL bp_release_transfers: got %0d, expected 1", n_out - out_before); end
    for (int i = 7; i < 16; i++) send_elem(0, i, 4, 4, w0);
    wait_drain();
    n_cmp++;
    if (n_out - out0 != 4) begin n_fail++; $display("FAIL bp_out_count: got %0d, expected 4", n_out - out0); end
  endtask

  task automatic test_reset_mid();
    int w0, out0;
    start_test(0);
    for (int i = 0; i < 16; i++) map_q.push_back(rand_fp());
    model_pool(4, 4, 1);
    for (int i = 0; i < 7; i++) send_elem(0, i, 4, 4, w0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b, expected 0", out_valid[0]); end
    n_cmp++;
    if (out_data[0] !== 16'h0000) begin n_fail++; $display("FAIL midrst_out_data: got %h, expected 0000", out_data[0]); end
    n_cmp++;
    if (in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready: got %b, expected 0", in_ready[0]); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL midrst_first_window: %0d outputs missing, expected 0", exp_q.size()); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    start_test(0);
    out0 = n_out;
    for (int i = 0; i < 16; i++) map_q.push_back(rand_fp());
    model_pool(4, 4, 1);
    for (int i = 0; i < 16; i++) send_elem(0, i, 4, 4, w0);
    wait_drain();
    n_cmp++;
    if (n_out - out0 != 4) begin n_fail++; $display("FAIL midrst_out_count: got %0d, expected 4", n_out - out0); end
    n_cmp++;
    if (fd_at_acc != 16) begin n_fail++; $display("FAIL midrst_frame_done_time: after %0d accepts, expected 16", fd_at_acc); end
  endtask

  task automatic test_odd_dims();
    int w0, out0;
    start_test(1);
    out0 = n_out;
    for (int ch = 0; ch < 2; ch++)
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          map_q.push_back((r == 4 || c == 4) ? 16'h7BFF : (rand_fp() & 16'hBFFF));
    model_pool(5, 5, 2);
    drive_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 50; i++) send_elem(1, i, 5, 5, w0);
        drive_done = 1'b1;
      end
      begin
        while (!drive_done) begin
          @(posedge clk);
          #1;
          out_ready[1] = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready[1] = 1'b1;
    wait_drain();
    n_cmp++;
    if (n_out - out0 != 8) begin n_fail++; $display("FAIL odd_out_count: got %0d, expected 8", n_out - out0); end
    n_cmp++;
    if (fd_cnt != 1) begin n_fail++; $display("FAIL odd_frame_done_count: got %0d, expected 1", fd_cnt); end
    n_cmp++;
    if (fd_at_acc != 50) begin n_fail++; $display("FAIL odd_frame_done_time: after %0d accepts, expected 50", fd_at_acc); end
  endtask

  task automatic test_back_to_back();
    int wt, max_wait, wait_13th, out0;
    start_test(2);
    out0     = n_out;
    max_wait = 0;
    for (int i = 0; i < 16; i++) map_q.push_back(rand_fp());
    model_pool(2, 2, 4);
    for (int i = 0; i < 16; i++) begin
      send_elem(2, i, 2, 2, wt);
      if (wt > max_wait) max_wait = wt;
      if (i == 12) wait_13th = wt;
    end
    wait_drain();
    n_cmp++;
    if (max_wait != 0) begin n_fail++; $display("FAIL b2b_stall: max wait %0d cycles, expected 0", max_wait); end
    n_cmp++;
    if (wait_13th != 0) begin n_fail++; $display("FAIL b2b_next_frame_accept: waited %0d cycles, expected 0", wait_13th); end
    n_cmp++;
    if (n_out - out0 != 4) begin n_fail++; $display("FAIL b2b_out_count: got %0d, expected 4", n_out - out0); end
    n_cmp++;
    if (fd_cnt != 1) begin n_fail++; $display("FAIL b2b_frame_done_count: got %0d, expected 1", fd_cnt); end
    n_cmp++;
    if (fd_at_acc != 12) begin n_fail++; $display("FAIL b2b_frame_done_time: after %0d accepts, expected 12", fd_at_acc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_backpressure();
    test_reset_mid();
    test_odd_dims();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
